// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, 3-sample majority vote per bit and framing-error detection.
// Latency: rx_valid/frame_err pulse one clk after the stop bit is decided (sub-tick 9 of stop bit, + 2 clk synchronizer).
// Backpressure: none; the consumer must take rx_data on the rx_valid pulse (rx_data then holds until the next good frame).
module uart_rx (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] baudrate_cfg,
  input  logic        rx,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic        frame_err,
  output logic        rx_busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t      state;
  logic        rx_meta;
  logic        rx_sync;
  logic        rx_prev;
  logic [15:0] cfg_q;
  logic [15:0] presc;
  logic [3:0]  sub_cnt;
  logic [2:0]  bit_idx;
  logic        samp7;
  logic        samp8;
  logic [7:0]  shift_reg;
  logic        tick;
  logic        vote;

  // Sub-tick strobe from the prescaler, using the divider frozen at the start edge.
  assign tick = (presc == cfg_q);

  // Majority of the samples taken at sub-ticks 7, 8 and the live one at sub-tick 9.
  assign vote = (samp7 & samp8) | (samp7 & rx_sync) | (samp8 & rx_sync);

  assign rx_busy = (state != IDLE);

  // Two-flop synchronizer plus one history flop for falling-edge detection; idle level is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Receive FSM: start detection, bit timing, sampling, shifting and registered output pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cfg_q     <= 16'd0;
      presc     <= 16'd0;
      sub_cnt   <= 4'd0;
      bit_idx   <= 3'd0;
      samp7     <= 1'b1;
      samp8     <= 1'b1;
      shift_reg <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          // The edge test looks at registered history, so an edge landing as
          // STOP hands back to IDLE is still seen here.
          if (rx_prev && !rx_sync) begin
            state   <= START;
            presc   <= 16'd0;
            sub_cnt <= 4'd0;
            bit_idx <= 3'd0;
            cfg_q   <= baudrate_cfg;
          end
        end

        START, DATA, STOP: begin
          if (tick) begin
            presc   <= 16'd0;
            sub_cnt <= sub_cnt + 4'd1;
            if (sub_cnt == 4'd7) samp7 <= rx_sync;
            if (sub_cnt == 4'd8) samp8 <= rx_sync;
            if (state == START) begin
              if (sub_cnt == 4'd9 && vote) begin
                state <= IDLE;
              end else if (sub_cnt == 4'd15) begin
                state <= DATA;
              end
            end else if (state == DATA) begin
              if (sub_cnt == 4'd9) shift_reg <= {vote, shift_reg[7:1]};
              if (sub_cnt == 4'd15) begin
                if (bit_idx == 3'd7) state <= STOP;
                else                 bit_idx <= bit_idx + 3'd1;
              end
            end else begin
              // Stop bit is decided mid-bit so the next start edge cannot be missed.
              if (sub_cnt == 4'd9) begin
                if (vote) begin
                  rx_data  <= shift_reg;
                  rx_valid <= 1'b1;
                  state    <= IDLE;
                end else begin
                  frame_err <= 1'b1;
                  state     <= WAIT_HIGH;
                end
              end
            end
          end else begin
            presc <= presc + 16'd1;
          end
        end

        WAIT_HIGH: begin
          // A held-low line (break) parks here without further pulses.
          if (rx_sync) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port baudrate_cfg, input, 16 bits: sub-tick divider; one sub-tick = baudrate_cfg+1 clk cycles; one bit = 16 sub-ticks.
REQ-004 SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-005 SHALL have port rx_valid, output, 1 bit: one-cycle pulse, new byte on rx_data.
REQ-006 SHALL have port rx_data, output, 8 bits: last correctly received byte.
REQ-007 SHALL have port frame_err, output, 1 bit: one-cycle pulse, stop bit sampled low.
REQ-008 SHALL have port rx_busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-009 SHALL use frame format 8N1: start bit 0, 8 data bits LSB first, 1 stop bit 1.
REQ-010 SHALL pass rx through a 2-flop synchronizer; all decoding uses the synchronized signal only.
REQ-011 SHALL run a sub-tick prescaler counting 0..baudrate_cfg, cleared on start detection, so that sub-tick phase is aligned to the start edge.
REQ-012 SHALL latch baudrate_cfg at start detection; changes mid-frame have no effect until the next frame.
REQ-013 SHALL use states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-014 IDLE -> START on synchronized rx high-to-low transition; sub-tick counter and bit counter cleared.
REQ-015 SHALL take each bit value as the majority of three samples at sub-ticks 7, 8, 9 of that bit.
REQ-016 START: majority 1 (false start/glitch) -> IDLE with no output pulse; majority 0 -> DATA at end of sub-tick 15.
REQ-017 DATA: shift majority value into a shift register LSB first; after bit index 7 completes sub-tick 15 -> STOP.
REQ-018 STOP: majority decided at end of sub-tick 9; majority 1 -> rx_data loaded, rx_valid pulsed next cycle, state -> IDLE immediately (no wait for sub-tick 15).
REQ-019 STOP: majority 0 -> frame_err pulsed next cycle, rx_data unchanged, no rx_valid, state -> WAIT_HIGH.
REQ-020 WAIT_HIGH -> IDLE when synchronized rx is 1; a break (line held low) keeps the block in WAIT_HIGH indefinitely with no further pulses.
REQ-021 rx_data SHALL hold its value between frames and change only coincident with rx_valid.
REQ-022 rx_valid and frame_err SHALL never assert in the same cycle and each is exactly one cycle wide.
REQ-023 A start edge arriving in the cycle IDLE is re-entered from STOP SHALL be detected (back-to-back frames, no lost byte).
REQ-024 baudrate_cfg=0 SHALL be legal (sub-tick every cycle); no other divider value is special-cased.

Reset
REQ-025 On rst high at a clk edge: state IDLE, rx_valid 0, frame_err 0, rx_busy 0, rx_data 8'h00, counters 0, synchronizer flops 1.
REQ-026 rst asserted mid-frame SHALL abort the frame with no rx_valid or frame_err pulse; after release, reception resumes only on a fresh falling edge.

Verification
REQ-027 baudrate_cfg=18 (304 clk/bit), send 0xA5 -> single rx_valid with rx_data=0xA5 about 9.5 bit times (~2890 clk) after start edge; frame_err stays 0.
REQ-028 Back-to-back frames 0x00 then 0xFF with no idle gap -> two rx_valid pulses, data 0x00 then 0xFF, no error.
REQ-029 rx low for 100 clk (< half bit) then high -> state returns to IDLE, no rx_valid, no frame_err.
REQ-030 Send 0x3C with stop bit forced 0, line then held low 5 bit times -> one frame_err pulse, rx_data keeps previous value, rx_busy high until line returns high.
REQ-031 One-clk-cycle inverted glitch at sub-tick 8 of data bit 3 of 0x55 -> rx_data=0x55 (majority vote rejects glitch).
REQ-032 rst pulsed during DATA of a frame -> all outputs at reset values, no pulse for that frame; next clean frame 0x81 received correctly.
